// File: rtl/sap_core.sv
// sap_core: parametrised accumulator CPU with program RAM,
// carry/zero flags, conditional jumps and step-qualified T-states.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   step          clock enable, one T-state per qualified edge
//   prog_mode     1 = load program (core held), 0 = run
//   prog_we       RAM write strobe, honoured only in prog_mode
//   prog_addr     RAM write address
//   prog_data     RAM write data
//   out_data      output register
//   out_valid     one-cycle pulse when out_data is updated
//   halted        high once HLT has executed
//   pc            program counter
//   flag_c        carry flag (1 = no borrow on SUB)
//   flag_z        zero flag

module sap_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_c,
    output logic              flag_z
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int IMM_W = DATA_W - OP_W;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
    localparam logic [OP_W-1:0] OP_STA = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDI = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JC  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_JZ  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(14);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

    if (DATA_W < OP_W + ADDR_W) begin : g_bad_widths
        $error("sap_core: DATA_W must be >= OP_W + ADDR_W");
    end

    // Architectural state
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] breg;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] mar;
    logic [2:0]        t_state;

    // Instruction fields
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] arg;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rd_data;

    assign op      = ir[DATA_W-1 -: OP_W];
    assign arg     = ir[ADDR_W-1:0];
    assign imm     = {{OP_W{1'b0}}, ir[IMM_W-1:0]};
    assign rd_data = mem[mar];

    // One-hot opcode decode; unlisted opcodes leave all low (NOP)
    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_sta;
    logic is_ldi;
    logic is_jmp;
    logic is_jc;
    logic is_jz;
    logic is_out;
    logic is_hlt;
    logic uses_mar;

    always_comb begin
        is_lda   = (op == OP_LDA);
        is_add   = (op == OP_ADD);
        is_sub   = (op == OP_SUB);
        is_sta   = (op == OP_STA);
        is_ldi   = (op == OP_LDI);
        is_jmp   = (op == OP_JMP);
        is_jc    = (op == OP_JC);
        is_jz    = (op == OP_JZ);
        is_out   = (op == OP_OUT);
        is_hlt   = (op == OP_HLT);
        uses_mar = is_lda | is_add | is_sub | is_sta;
    end

    // SUB is A + ~B + 1, so the carry out reads as "no borrow"
    logic [DATA_W:0] alu_sum;

    always_comb begin
        alu_sum = {1'b0, acc}
                + {1'b0, (is_sub ? ~breg : breg)}
                + {{DATA_W{1'b0}}, is_sub};
    end

    // Next-state values for one qualified T-state
    logic [DATA_W-1:0] acc_n;
    logic [DATA_W-1:0] breg_n;
    logic [DATA_W-1:0] ir_n;
    logic [ADDR_W-1:0] mar_n;
    logic [ADDR_W-1:0] pc_n;
    logic              c_n;
    logic              z_n;
    logic              halt_n;
    logic [DATA_W-1:0] out_n;
    logic              ov_n;
    logic [2:0]        t_n;
    logic              sta_we;

    always_comb begin
        acc_n  = acc;
        breg_n = breg;
        ir_n   = ir;
        mar_n  = mar;
        pc_n   = pc;
        c_n    = flag_c;
        z_n    = flag_z;
        halt_n = halted;
        out_n  = out_data;
        ov_n   = 1'b0;
        sta_we = 1'b0;
        t_n    = (t_state == T4) ? T0 : t_state + 3'd1;

        unique case (t_state)
            T0: begin
                mar_n = pc;
            end
            T1: begin
                ir_n = rd_data;
                pc_n = pc + ADDR_W'(1);
            end
            T2: begin
                unique case (1'b1)
                    uses_mar: mar_n = arg;
                    is_ldi:   acc_n = imm;
                    is_jmp:   pc_n  = arg;
                    is_jc:    if (flag_c) pc_n = arg;
                    is_jz:    if (flag_z) pc_n = arg;
                    is_out: begin
                        out_n = acc;
                        ov_n  = 1'b1;
                    end
                    is_hlt:   halt_n = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                unique case (1'b1)
                    is_lda:          acc_n  = rd_data;
                    is_add | is_sub: breg_n = rd_data;
                    is_sta:          sta_we = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                if (is_add | is_sub) begin
                    acc_n = alu_sum[DATA_W-1:0];
                    c_n   = alu_sum[DATA_W];
                    z_n   = (alu_sum[DATA_W-1:0] == '0);
                end
            end
            default: begin
                t_n = T0;
            end
        endcase
    end

    // Priority: rst > prog_mode > halted > step
    logic advance;

    assign advance = !rst && !prog_mode && !halted && step;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            breg      <= '0;
            ir        <= '0;
            mar       <= '0;
            pc        <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            t_state   <= T0;
            halted    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (prog_mode) begin
            // out_data keeps its last value across program loads
            acc       <= '0;
            breg      <= '0;
            ir        <= '0;
            mar       <= '0;
            pc        <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            t_state   <= T0;
            halted    <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            acc       <= acc_n;
            breg      <= breg_n;
            ir        <= ir_n;
            mar       <= mar_n;
            pc        <= pc_n;
            flag_c    <= c_n;
            flag_z    <= z_n;
            t_state   <= t_n;
            halted    <= halt_n;
            out_data  <= out_n;
            out_valid <= ov_n;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Single RAM write port shared by program load and STA
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = mar;
        ram_wdata = acc;
        if (!rst) begin
            if (prog_mode) begin
                ram_we    = prog_we;
                ram_addr  = prog_addr;
                ram_wdata = prog_data;
            end else begin
                ram_we = advance & sta_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

endmodule
